// File: rtl/servo_seq_pkg.sv
// servo_seq_pkg
//   Shared types and constants for the waypoint sequencer:
//     seq_state_t      - sequencer FSM states
//     BTN_ADD/SUB/HOLD - 2-bit per-channel step request encodings
//     BTN_W            - width of one channel's step request field
package servo_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int BTN_W = 2;

    localparam logic [BTN_W-1:0] BTN_ADD  = 2'b01;
    localparam logic [BTN_W-1:0] BTN_SUB  = 2'b10;
    localparam logic [BTN_W-1:0] BTN_HOLD = 2'b00;

endpackage

// File: rtl/waypoint_table.sv
// waypoint_table
//   DEPTH x WIDTH register file holding the waypoint path.
//   Synchronous write, combinational (same-cycle) read so the compare logic
//   always sees table[idx] without an extra pipeline stage. Not reset.
//   Ports:
//     clk      in  - clock
//     wr_en    in  - write strobe
//     wr_addr  in  - write index
//     wr_data  in  - write data (one packed waypoint)
//     rd_addr  in  - read index
//     rd_data  out - table[rd_addr]
module waypoint_table
    import servo_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/waypoint_sequencer.sv
// waypoint_sequencer
//   Drives N servo channels through a run-time loadable table of waypoints.
//   Each channel gets an add/sub/hold step request toward table[idx]; once
//   every channel is within TOL the sequencer advances (one-shot or looping).
//   Optional feature macro: WAYPOINT_DWELL_EN builds a DWELL state that holds
//   all channels still for DWELL_CYCLES after each arrival.
//   Ports:
//     clk, rst    in  - clock, asynchronous active-high reset
//     enable      in  - run gate; low freezes the FSM and zeroes btn
//     start       in  - launch pulse (honoured in IDLE/DONE only)
//     loop        in  - wrap to index 0 after the last waypoint
//     num_points  in  - number of active table entries (0 inhibits start)
//     wr_en/wr_addr/wr_data in - table write port
//     pos         in  - current channel positions, channel k at [k*W +: W]
//     btn         out - step requests, channel k at [2k +: 2]
//     idx         out - current waypoint index
//     busy        out - moving or dwelling
//     done        out - finished a one-shot path, holding the last point
module waypoint_sequencer
    import servo_seq_pkg::*;
#(
    parameter int N            = 5,
    parameter int W            = 8,
    parameter int DEPTH        = 8,
    parameter int TOL          = 0,
    parameter int DWELL_CYCLES = 2**20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       start,
    input  logic                       loop,
    input  logic [$clog2(DEPTH+1)-1:0] num_points,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [N*W-1:0]             wr_data,
    input  logic [N*W-1:0]             pos,
    output logic [2*N-1:0]             btn,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic                       busy,
    output logic                       done
);

    localparam int IW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);
    // Tolerance at W+1 bits so pos+TOL cannot wrap near the top of range.
    localparam logic [W:0] TOL_EXT = (W+1)'(TOL);

    seq_state_t         state_reg;
    logic [N*W-1:0]     target;
    logic [2*N-1:0]     cmp_btn;
    logic [N-1:0]       arrived;
    logic               all_arrived;
    logic               last_point;
    logic [IW-1:0]      adv_idx;
    seq_state_t         adv_state;

    waypoint_table #(
        .DEPTH (DEPTH),
        .WIDTH (N*W)
    ) u_table (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx),
        .rd_data (target)
    );

    // Per-channel direction compare, unsigned at W+1 bits.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            logic [W:0]       pos_ext;
            logic [W:0]       tgt_ext;
            logic [BTN_W-1:0] ch_btn;

            assign pos_ext = {1'b0, pos[gi*W +: W]};
            assign tgt_ext = {1'b0, target[gi*W +: W]};

            always_comb begin
                ch_btn = BTN_HOLD;
                if (pos_ext + TOL_EXT < tgt_ext) begin
                    ch_btn = BTN_ADD;
                end else if (pos_ext > tgt_ext + TOL_EXT) begin
                    ch_btn = BTN_SUB;
                end
            end

            assign cmp_btn[BTN_W*gi +: BTN_W] = ch_btn;
            assign arrived[gi]                = (ch_btn == BTN_HOLD);
        end
    endgenerate

    assign all_arrived = &arrived;

    // idx >= num_points-1 also catches num_points being shrunk below idx
    // mid-run, which is then handled like reaching the last point.
    assign last_point = (NW'(idx) + NW'(1) >= num_points);

    always_comb begin
        adv_idx   = idx + IW'(1);
        adv_state = MOVE;
        if (last_point) begin
            if (loop) begin
                adv_idx = '0;
            end else begin
                adv_idx   = idx;
                adv_state = DONE;
            end
        end
    end

`ifdef WAYPOINT_DWELL_EN
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    logic [CNT_W-1:0] dwell_cnt_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx       <= '0;
            btn       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef WAYPOINT_DWELL_EN
            dwell_cnt_reg <= '0;
`endif
        end else if (!enable) begin
            // Frozen: everything holds except the step requests.
            btn <= '0;
        end else begin
            btn <= '0;
            case (state_reg)
                IDLE, DONE: begin
                    // DONE keeps servoing toward the final waypoint.
                    if (state_reg == DONE) begin
                        btn <= cmp_btn;
                    end
                    if (start && (num_points != '0)) begin
                        state_reg <= MOVE;
                        idx       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        btn       <= '0;
                    end
                end
                MOVE: begin
                    btn <= cmp_btn;
                    if (all_arrived) begin
`ifdef WAYPOINT_DWELL_EN
                        state_reg     <= DWELL;
                        dwell_cnt_reg <= '0;
`else
                        state_reg <= adv_state;
                        idx       <= adv_idx;
                        busy      <= (adv_state == MOVE);
                        done      <= (adv_state == DONE);
`endif
                    end
                end
`ifdef WAYPOINT_DWELL_EN
                DWELL: begin
                    // Drift during the dwell is deliberately ignored.
                    if (dwell_cnt_reg == DWELL_LAST) begin
                        state_reg <= adv_state;
                        idx       <= adv_idx;
                        busy      <= (adv_state == MOVE);
                        done      <= (adv_state == DONE);
                    end else begin
                        dwell_cnt_reg <= dwell_cnt_reg + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
